// File: rtl/mux_sel_sequencer_if.sv
// Handshake bundle between the round-robin select sequencer and its
// environment: channel requests and downstream ready in, mux select pair,
// grant vector and status out.
interface mux_sel_sequencer_if;
   logic [3:0] req;
   logic       out_ready;
   logic       s1;
   logic       s0;
   logic [3:0] grant;
   logic       out_valid;
   logic       burst_done;

   // Sequencer side: drives the mux selects and status.
   modport master (
      input  req,
      input  out_ready,
      output s1,
      output s0,
      output grant,
      output out_valid,
      output burst_done
   );

   // Environment side: requesting channels and downstream consumer.
   modport slave (
      output req,
      output out_ready,
      input  s1,
      input  s0,
      input  grant,
      input  out_valid,
      input  burst_done
   );
endinterface

// File: rtl/mux_sel_sequencer.sv
// Round-robin select generator for a 4:1 channel mux. A grant is held for up
// to BURST_LEN accepted transfers (or until the owner drops its request),
// then priority rotates to the channel after the one just served. One idle
// bubble always separates consecutive grants.
module mux_sel_sequencer #(
   parameter int BURST_LEN = 4,
   parameter int CNT_W     = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   mux_sel_sequencer_if.master bus
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

   state_t           state_q, state_d;
   logic [1:0]       sel_q,   sel_d;
   logic [3:0]       grant_q, grant_d;
   logic             done_q,  done_d;
   logic [1:0]       ptr_q,   ptr_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic [2:0]       win_s;
   logic             valid_s;

   // Returns {found, index} of the first requester scanning from p upward
   // (mod 4). The scan runs backwards so the nearest hit is written last.
   function automatic logic [2:0] pick_winner(input logic [3:0] r, input logic [1:0] p);
      logic [2:0] res;
      logic [1:0] c;
      res = 3'b000;
      for (int k = 3; k >= 0; k--) begin
         c = p + 2'(k);
         if (r[c]) begin
            res = {1'b1, c};
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

   assign win_s   = pick_winner(bus.req, ptr_q);
   // Valid only while the owner still requests; other channels are ignored.
   assign valid_s = (state_q == ST_BUSY) && bus.req[sel_q];

   // Next-state and output decode for the grant FSM.
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      grant_d = grant_q;
      done_d  = 1'b0;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (win_s[2]) begin
               state_d = ST_BUSY;
               sel_d   = win_s[1:0];
               grant_d = 4'b0001 << win_s[1:0];
               cnt_d   = {CNT_W{1'b0}};
            end else begin
               grant_d = 4'b0000;
            end
         end
         ST_BUSY: begin
            if (!valid_s || (bus.out_ready && (cnt_q == CNT_LAST))) begin
               // Grant ends: owner dropped out or burst is complete.
               state_d = ST_IDLE;
               grant_d = 4'b0000;
               ptr_d   = sel_q + 2'd1;
               cnt_d   = {CNT_W{1'b0}};
               done_d  = 1'b1;
            end else if (bus.out_ready) begin
               cnt_d = cnt_q + CNT_W'(1);
            end else begin
               // Stall: downstream not ready, everything held.
               cnt_d = cnt_q;
            end
         end
         default: begin
            state_d = ST_IDLE;
            sel_d   = 2'b00;
            grant_d = 4'b0000;
            ptr_d   = 2'b00;
            cnt_d   = {CNT_W{1'b0}};
         end
      endcase
   end

   // State, select, grant, pointer and counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         sel_q   <= 2'b00;
         grant_q <= 4'b0000;
         done_q  <= 1'b0;
         ptr_q   <= 2'b00;
         cnt_q   <= {CNT_W{1'b0}};
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         grant_q <= grant_d;
         done_q  <= done_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.s1         = sel_q[1];
   assign bus.s0         = sel_q[0];
   assign bus.grant      = grant_q;
   assign bus.burst_done = done_q;
   assign bus.out_valid  = valid_s;

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Directed plus randomized bench for mux_sel_sequencer. Two instances:
// BURST_LEN=4 (dut_a) and BURST_LEN=1 (dut_b), sharing clock, reset and
// inputs; a transaction-level model tracks whichever one is under test.
module tb_mux_sel_sequencer;
   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] req_r;
   logic       rdy_r;

   mux_sel_sequencer_if ifa ();
   mux_sel_sequencer_if ifb ();

   assign ifa.req       = req_r;
   assign ifa.out_ready = rdy_r;
   assign ifb.req       = req_r;
   assign ifb.out_ready = rdy_r;

   mux_sel_sequencer #(.BURST_LEN(4), .CNT_W(3)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
   mux_sel_sequencer #(.BURST_LEN(1), .CNT_W(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;
   bit use_b    = 1'b0;

   // Reference model: who owns the mux, how many transfers it has had.
   int m_bl;
   bit m_busy;
   int m_ch;
   int m_xfers;
   int m_ptr;
   bit m_done;

   // Rotation monitor.
   bit mon_on = 1'b0;
   int rot_q[$];
   int done_cnt;
   int prev_grant;

   function automatic int o_sel();
      return use_b ? int'({ifb.s1, ifb.s0}) : int'({ifa.s1, ifa.s0});
   endfunction
   function automatic int o_grant();
      return use_b ? int'(ifb.grant) : int'(ifa.grant);
   endfunction
   function automatic int o_valid();
      return use_b ? int'(ifb.out_valid) : int'(ifa.out_valid);
   endfunction
   function automatic int o_done();
      return use_b ? int'(ifb.burst_done) : int'(ifa.burst_done);
   endfunction

   function automatic int e_valid();
      return (m_busy && req_r[m_ch]) ? 1 : 0;
   endfunction
   function automatic int e_grant();
      return m_busy ? (1 << m_ch) : 0;
   endfunction

   task automatic chk(input string tag, input int obs, input int exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_busy  = 1'b0;
      m_ch    = 0;
      m_xfers = 0;
      m_ptr   = 0;
      m_done  = 1'b0;
   endtask

   task automatic model_edge(input logic [3:0] r, input logic rd);
      bit ended;
      bit found;
      ended  = 1'b0;
      found  = 1'b0;
      m_done = 1'b0;
      if (m_busy) begin
         if (!r[m_ch]) ended = 1'b1;
         else if (rd) begin
            m_xfers++;
            if (m_xfers == m_bl) ended = 1'b1;
         end
         if (ended) begin
            m_busy  = 1'b0;
            m_ptr   = (m_ch + 1) % 4;
            m_xfers = 0;
            m_done  = 1'b1;
         end
      end else if (r != 4'b0000) begin
         for (int k = 0; k < 4; k++) begin
            if (!found && r[(m_ptr + k) % 4]) begin
               found   = 1'b1;
               m_ch    = (m_ptr + k) % 4;
               m_busy  = 1'b1;
               m_xfers = 0;
            end
         end
      end
   endtask

   // One clock: drive inputs after the falling edge, check before and after
   // the rising edge, return at the next falling edge.
   task automatic cycle(input logic [3:0] r, input logic rd);
      req_r = r;
      rdy_r = rd;
      #1;
      chk("valid_pre", o_valid(), e_valid());
      @(posedge clk);
      model_edge(r, rd);
      #1;
      chk("sel", o_sel(), m_ch);
      chk("grant", o_grant(), e_grant());
      chk("burst_done", o_done(), int'(m_done));
      chk("valid_post", o_valid(), e_valid());
      if (mon_on && o_grant() != 0 && prev_grant == 0) rot_q.push_back(o_sel());
      if (mon_on && o_done() != 0) done_cnt++;
      prev_grant = o_grant();
      @(negedge clk);
   endtask

   // Reset asserted between edges; outputs must clear without a clock.
   task automatic async_reset();
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_sel", o_sel(), 0);
      chk("rst_grant", o_grant(), 0);
      chk("rst_valid", o_valid(), 0);
      chk("rst_done", o_done(), 0);
      model_reset();
      prev_grant = 0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   logic [3:0] rnd_req;
   logic       rnd_rdy;

   initial begin
      m_bl  = 4;
      req_r = 4'hF;
      rdy_r = 1'b1;
      rst_n = 1'b0;
      model_reset();
      prev_grant = 0;

      // 1: reset with every channel requesting.
      #3;
      chk("reset_sel", o_sel(), 0);
      chk("reset_grant", o_grant(), 0);
      chk("reset_valid", o_valid(), 0);
      chk("reset_done", o_done(), 0);
      @(posedge clk);
      #1;
      chk("reset_hold_grant", o_grant(), 0);
      chk("reset_hold_valid", o_valid(), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // 2: rotation 0,1,2,3,0 with four transfers each and one bubble between.
      mon_on   = 1'b1;
      done_cnt = 0;
      rot_q.delete();
      repeat (25) cycle(4'hF, 1'b1);
      mon_on = 1'b0;
      chk("rot_count", rot_q.size(), 5);
      if (rot_q.size() == 5) begin
         chk("rot_0", rot_q[0], 0);
         chk("rot_1", rot_q[1], 1);
         chk("rot_2", rot_q[2], 2);
         chk("rot_3", rot_q[3], 3);
         chk("rot_4", rot_q[4], 0);
      end
      chk("rot_done_pulses", done_cnt, 5);

      // 3: grant ch2, stall five cycles, then ch2 drops its request.
      cycle(4'b0100, 1'b0);
      chk("stall_grant", o_grant(), 4);
      repeat (5) cycle(4'b0100, 1'b0);
      chk("stall_sel", o_sel(), 2);
      cycle(4'b0000, 1'b0);
      chk("drop_done", o_done(), 1);
      chk("drop_grant", o_grant(), 0);

      // 4: ptr=3 with only ch1 requesting wraps to ch1; afterwards ptr=2.
      cycle(4'b0010, 1'b1);
      chk("wrap_grant", o_grant(), 2);
      chk("wrap_sel", o_sel(), 1);
      repeat (4) cycle(4'b0010, 1'b1);
      chk("wrap_end_done", o_done(), 1);
      cycle(4'b1111, 1'b1);
      chk("ptr2_grant", o_grant(), 4);
      cycle(4'b0000, 1'b1);
      cycle(4'b1001, 1'b1);
      chk("ptr3_grant", o_grant(), 8);
      cycle(4'b0000, 1'b1);

      // 5: asynchronous reset after two transfers of a burst.
      cycle(4'b1111, 1'b1);
      cycle(4'b1111, 1'b1);
      cycle(4'b1111, 1'b1);
      async_reset();
      cycle(4'b0001, 1'b1);
      chk("post_reset_grant", o_grant(), 1);

      // Randomized traffic on the BURST_LEN=4 instance.
      rnd_req = 4'hF;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0) rnd_req = 4'($urandom_range(0, 15));
         rnd_rdy = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 79) == 0) async_reset();
         cycle(rnd_req, rnd_rdy);
      end

      // 6: BURST_LEN=1, channels 0 and 3 alternate one transfer each.
      use_b = 1'b1;
      m_bl  = 1;
      async_reset();
      mon_on = 1'b1;
      rot_q.delete();
      done_cnt = 0;
      repeat (8) cycle(4'b1001, 1'b1);
      mon_on = 1'b0;
      chk("bl1_count", rot_q.size(), 4);
      if (rot_q.size() == 4) begin
         chk("bl1_0", rot_q[0], 0);
         chk("bl1_1", rot_q[1], 3);
         chk("bl1_2", rot_q[2], 0);
         chk("bl1_3", rot_q[3], 3);
      end
      chk("bl1_done_pulses", done_cnt, 4);

      // Randomized traffic on the BURST_LEN=1 instance.
      for (int i = 0; i < 200; i++) begin
         if ($urandom_range(0, 2) == 0) rnd_req = 4'($urandom_range(0, 15));
         rnd_rdy = ($urandom_range(0, 3) != 0);
         cycle(rnd_req, rnd_rdy);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
